mux_rr_stream_nch: RTL and testbench

//  - CH-channel, WIDTH-bit stream multiplexer with valid/ready handshakes on every input and the output.
//  - Channel selection is a fair round-robin arbiter, not an external select line.
//  - The output is registered: one beat per cycle, 1-cycle latency, output held stable under backpressure.
//  - Sits between parallel producers (DMA/sensor lanes) and one shared downstream consumer.

---
 rtl/mux_rr_stream_nch.sv | 117 +++++++++++
 tb/tb_mux_rr_stream_nch.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_stream_nch.sv
// CH-channel valid/ready stream multiplexer with a round-robin arbiter and a registered output.
// Define MUX_PKT_LOCK_EN to add in_last and hold the grant on one channel until the end of a packet.
module mux_rr_stream_nch #(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    parameter int SELW  = $clog2(CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH*WIDTH-1:0] in_data,
    input  logic [CH-1:0]       in_valid,
    output logic [CH-1:0]       in_ready,
`ifdef MUX_PKT_LOCK_EN
    input  logic [CH-1:0]       in_last,
`endif
    output logic [WIDTH-1:0]    out_data,
    output logic                out_valid,
    output logic [SELW-1:0]     out_sel,
    input  logic                out_ready
);

    logic [SELW-1:0]  rr_ptr;
    logic [CH-1:0]    grant;
    logic [SELW-1:0]  grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             load;
    logic             xfer;
    logic             found;
    int               best_dist;

    // Distance of channel i from the highest-priority slot (rr_ptr+1), wrapping at CH-1.
    function automatic int rr_dist(input int i, input logic [SELW-1:0] p);
        return (i + CH - 1 - int'(p)) % CH;
    endfunction

    assign load = ~out_valid | out_ready;

`ifdef MUX_PKT_LOCK_EN
    logic lock;
    logic grant_last;
`endif

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        found     = 1'b0;
        best_dist = CH;
        grant_idx = '0;
        for (int i = 0; i < CH; i++) begin
            if (in_valid[i] && rr_dist(i, rr_ptr) < best_dist) begin
                best_dist = rr_dist(i, rr_ptr);
                grant_idx = SELW'(i);
                found     = 1'b1;
            end
        end
`ifdef MUX_PKT_LOCK_EN
        // While a packet is open the grant stays on the channel that started it.
        if (lock) begin
            found     = 1'b1;
            grant_idx = out_sel;
        end
`endif
        grant = '0;
        for (int i = 0; i < CH; i++) begin
            grant[i] = found && (grant_idx == SELW'(i));
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < CH; i++) begin
            if (grant[i]) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef MUX_PKT_LOCK_EN
    assign grant_last = |(grant & in_last);
`endif

    assign in_ready = grant & {CH{load}};
    assign xfer     = |(grant & in_valid) & load;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            rr_ptr    <= SELW'(CH - 1);
        end else if (load) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= grant_data;
                out_sel  <= grant_idx;
`ifdef MUX_PKT_LOCK_EN
                if (grant_last) begin
                    rr_ptr <= grant_idx;
                end
`else
                rr_ptr   <= grant_idx;
`endif
            end
        end
    end

`ifdef MUX_PKT_LOCK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock <= 1'b0;
        end else if (xfer) begin
            lock <= ~grant_last;
        end
    end
`endif

endmodule

// File: tb/tb_mux_rr_stream_nch.sv
// Scoreboard bench for mux_rr_stream_nch: a CH=4 instance plus a CH=3 instance for the wrap case.
// The packet-lock scenario is compiled only when MUX_PKT_LOCK_EN is defined.
module tb_mux_rr_stream_nch;

    typedef struct packed {
        logic       v;
        logic [1:0] sel;
        logic [7:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_data = '0;
    logic [3:0]  in_valid = '0;
    logic [3:0]  in_ready;
    logic [3:0]  in_last = '0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [1:0]  out_sel;
    logic        out_ready = 1'b0;

    logic [23:0] d3_in_data = '0;
    logic [2:0]  d3_in_valid = '0;
    logic [2:0]  d3_in_ready;
    logic [2:0]  d3_in_last = '1;
    logic [7:0]  d3_out_data;
    logic        d3_out_valid;
    logic [1:0]  d3_out_sel;
    logic        d3_out_ready = 1'b0;

    beat_t exp_q[$];
    beat_t exp_b;
    beat_t act_b;
    int    total = 0;
    int    bad   = 0;

    always #5 clk = ~clk;

    mux_rr_stream_nch #(.WIDTH(8), .CH(4)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef MUX_PKT_LOCK_EN
        .in_last(in_last),
`endif
        .out_data(out_data), .out_valid(out_valid), .out_sel(out_sel), .out_ready(out_ready)
    );

    mux_rr_stream_nch #(.WIDTH(8), .CH(3)) dut3 (
        .clk(clk), .rst(rst),
        .in_data(d3_in_data), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
`ifdef MUX_PKT_LOCK_EN
        .in_last(d3_in_last),
`endif
        .out_data(d3_out_data), .out_valid(d3_out_valid), .out_sel(d3_out_sel), .out_ready(d3_out_ready)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
        d3_in_valid = '0; d3_out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        total++;
        if ({out_valid, out_sel, out_data} !== 11'd0) begin
            bad++;
            $display("FAIL reset_out: got v=%0b sel=%0d data=%h, want all 0", out_valid, out_sel, out_data);
        end
        total++;
        if (d3_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out3: got v=%0b, want 0", d3_out_valid);
        end
        total++;
        if (in_ready !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ready: got %b, want 0000", in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        in_data[2*8 +: 8] = 8'hA5; in_valid = 4'b0100; out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0100) begin
            bad++;
            $display("FAIL single_ready: got %b, want 0100", in_ready);
        end
        exp_q.push_back('{v: 1'b1, sel: 2'd2, data: 8'hA5});
        @(posedge clk); #1;
        in_valid = 4'b0000;
        act_b = {out_valid, out_sel, out_data};
        exp_b = exp_q.pop_front();
        total++;
        if (act_b !== exp_b) begin
            bad++;
            $display("FAIL single_beat: got %h, want %h", act_b, exp_b);
        end
        exp_q.push_back('{v: 1'b0, sel: 2'd2, data: 8'hA5});
        @(posedge clk); #1;
        act_b = {out_valid, out_sel, out_data};
        exp_b = exp_q.pop_front();
        total++;
        if (act_b !== exp_b) begin
            bad++;
            $display("FAIL single_idle_hold: got %h, want %h", act_b, exp_b);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        in_data = 32'h13121110; in_valid = 4'b1111; out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            total++;
            if (in_ready !== (4'b0001 << (c % 4))) begin
                bad++;
                $display("FAIL rr_ready[%0d]: got %b, want %b", c, in_ready, 4'b0001 << (c % 4));
            end
            exp_q.push_back('{v: 1'b1, sel: 2'(c % 4), data: 8'h10 + 8'(c % 4)});
            @(posedge clk); #1;
            act_b = {out_valid, out_sel, out_data};
            exp_b = exp_q.pop_front();
            total++;
            if (act_b !== exp_b) begin
                bad++;
                $display("FAIL rr_beat[%0d]: got %h, want %h", c, act_b, exp_b);
            end
        end
    endtask

    task automatic test_sparse();
        logic [3:0] pat [4] = '{4'b1010, 4'b1010, 4'b1010, 4'b0001};
        logic [1:0] sel [4] = '{2'd1, 2'd3, 2'd1, 2'd0};
        do_reset();
        in_data = 32'h43424140; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_valid = pat[c];
            exp_q.push_back('{v: 1'b1, sel: sel[c], data: 8'h40 + 8'(sel[c])});
            @(posedge clk); #1;
            act_b = {out_valid, out_sel, out_data};
            exp_b = exp_q.pop_front();
            total++;
            if (act_b !== exp_b) begin
                bad++;
                $display("FAIL sparse_beat[%0d]: got %h, want %h", c, act_b, exp_b);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_data = 32'h13121110; in_valid = 4'b1111; out_ready = 1'b1;
        exp_q.push_back('{v: 1'b1, sel: 2'd0, data: 8'h10});
        exp_q.push_back('{v: 1'b1, sel: 2'd1, data: 8'h11});
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            act_b = {out_valid, out_sel, out_data};
            exp_b = exp_q.pop_front();
            total++;
            if (act_b !== exp_b) begin
                bad++;
                $display("FAIL bp_fill[%0d]: got %h, want %h", c, act_b, exp_b);
            end
        end
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (in_ready !== 4'b0000) begin
                bad++;
                $display("FAIL bp_ready[%0d]: got %b, want 0000", c, in_ready);
            end
            exp_q.push_back('{v: 1'b1, sel: 2'd1, data: 8'h11});
            @(posedge clk); #1;
            act_b = {out_valid, out_sel, out_data};
            exp_b = exp_q.pop_front();
            total++;
            if (act_b !== exp_b) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got %h, want %h", c, act_b, exp_b);
            end
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0100) begin
            bad++;
            $display("FAIL bp_release_ready: got %b, want 0100", in_ready);
        end
        exp_q.push_back('{v: 1'b1, sel: 2'd2, data: 8'h12});
        @(posedge clk); #1;
        act_b = {out_valid, out_sel, out_data};
        exp_b = exp_q.pop_front();
        total++;
        if (act_b !== exp_b) begin
            bad++;
            $display("FAIL bp_release_beat: got %h, want %h", act_b, exp_b);
        end
    endtask

    task automatic test_ch3_wrap();
        logic [2:0] pat [8] = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b111, 3'b111, 3'b111, 3'b111};
        logic [1:0] sel [8] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
        do_reset();
        d3_in_data = 24'h222120; d3_out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            d3_in_valid = pat[c];
            exp_q.push_back('{v: 1'b1, sel: sel[c], data: 8'h20 + 8'(sel[c])});
            @(posedge clk); #1;
            act_b = {d3_out_valid, d3_out_sel, d3_out_data};
            exp_b = exp_q.pop_front();
            total++;
            if (act_b !== exp_b) begin
                bad++;
                $display("FAIL ch3_beat[%0d]: got %h, want %h", c, act_b, exp_b);
            end
        end
        d3_in_valid = '0;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        in_data = 32'h13121110; in_valid = 4'b1111; out_ready = 1'b1;
        exp_q.push_back('{v: 1'b1, sel: 2'd0, data: 8'h10});
        @(posedge clk); #1;
        out_ready = 1'b0;
        act_b = {out_valid, out_sel, out_data};
        exp_b = exp_q.pop_front();
        total++;
        if (act_b !== exp_b) begin
            bad++;
            $display("FAIL mid_first: got %h, want %h", act_b, exp_b);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_async_drop: got v=%0b, want 0", out_valid);
        end
        #1 rst = 1'b0;
        out_ready = 1'b1;
        exp_q.push_back('{v: 1'b1, sel: 2'd0, data: 8'h10});
        @(posedge clk); #1;
        act_b = {out_valid, out_sel, out_data};
        exp_b = exp_q.pop_front();
        total++;
        if (act_b !== exp_b) begin
            bad++;
            $display("FAIL mid_restart: got %h, want %h", act_b, exp_b);
        end
    endtask

`ifdef MUX_PKT_LOCK_EN
    task automatic test_pkt_lock();
        logic [3:0] vld [5] = '{4'b0001, 4'b0111, 4'b0111, 4'b0111, 4'b0111};
        logic [3:0] lst [5] = '{4'b0001, 4'b0101, 4'b0101, 4'b0111, 4'b0111};
        logic [7:0] d1  [5] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h33};
        logic [3:0] rdy [5] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
        logic [1:0] sel [5] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
        do_reset();
        in_data = 32'h13_52_30_40; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_valid = vld[c]; in_last = lst[c]; in_data[15:8] = d1[c];
            #1;
            total++;
            if (in_ready !== rdy[c]) begin
                bad++;
                $display("FAIL lock_ready[%0d]: got %b, want %b", c, in_ready, rdy[c]);
            end
            exp_q.push_back('{v: 1'b1, sel: sel[c], data: (sel[c] == 2'd1) ? d1[c] : in_data[8*sel[c] +: 8]});
            @(posedge clk); #1;
            act_b = {out_valid, out_sel, out_data};
            exp_b = exp_q.pop_front();
            total++;
            if (act_b !== exp_b) begin
                bad++;
                $display("FAIL lock_beat[%0d]: got %h, want %h", c, act_b, exp_b);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_sparse();
        test_backpressure();
        test_ch3_wrap();
        test_reset_midstream();
`ifdef MUX_PKT_LOCK_EN
        test_pkt_lock();
`endif
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got %0d entries, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
